// File: rtl/core_quant_arbiter.sv
// Round-robin burst arbiter sharing one quant pipeline between NUM_REQ requesters.
// Latches the owner's config at grant and drains the pipeline before every owner switch.
module core_quant_arbiter #(
  parameter int NUM_REQ           = 2,
  parameter int IDATA_WIDTH       = 24,
  parameter int ODATA_BIT         = 8,
  parameter int CDATA_SCALE_WIDTH = 16,
  parameter int CDATA_BIAS_WIDTH  = 16,
  parameter int CDATA_SHIFT_WIDTH = 5,
  parameter int MAX_BURST         = 64,
  parameter int INFLIGHT_MAX      = 8
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ-1:0]                     req_last,
  input  logic [NUM_REQ*IDATA_WIDTH-1:0]         req_data,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*CDATA_SCALE_WIDTH-1:0]   req_cfg_scale,
  input  logic [NUM_REQ*CDATA_BIAS_WIDTH-1:0]    req_cfg_bias,
  input  logic [NUM_REQ*CDATA_SHIFT_WIDTH-1:0]   req_cfg_shift,
  output logic [CDATA_SCALE_WIDTH-1:0]           q_cfg_scale,
  output logic [CDATA_BIAS_WIDTH-1:0]            q_cfg_bias,
  output logic [CDATA_SHIFT_WIDTH-1:0]           q_cfg_shift,
  output logic [IDATA_WIDTH-1:0]                 q_idata,
  output logic                                   q_idata_valid,
  input  logic [ODATA_BIT-1:0]                   q_odata,
  input  logic                                   q_odata_valid,
  output logic [ODATA_BIT-1:0]                   rsp_data,
  output logic [NUM_REQ-1:0]                     rsp_valid,
  output logic                                   busy,
  output logic                                   err_underflow
);

  localparam int OW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int FW  = $clog2(INFLIGHT_MAX + 1);
  localparam int BCW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN} state_t;

  state_t                         state_q;
  logic [OW-1:0]                  owner_q;
  logic [OW-1:0]                  rr_q;
  logic [FW-1:0]                  inflight_q;
  logic [FW-1:0]                  inflight_d;
  logic [BCW-1:0]                 beats_q;
  logic [CDATA_SCALE_WIDTH-1:0]   cfg_scale_q;
  logic [CDATA_BIAS_WIDTH-1:0]    cfg_bias_q;
  logic [CDATA_SHIFT_WIDTH-1:0]   cfg_shift_q;
  logic [IDATA_WIDTH-1:0]         q_idata_q;
  logic                           q_idata_valid_q;
  logic [ODATA_BIT-1:0]           rsp_data_q;
  logic [NUM_REQ-1:0]             rsp_valid_q;
  logic                           err_q;

  logic [IDATA_WIDTH-1:0]         data_a  [NUM_REQ];
  logic [CDATA_SCALE_WIDTH-1:0]   scale_a [NUM_REQ];
  logic [CDATA_BIAS_WIDTH-1:0]    bias_a  [NUM_REQ];
  logic [CDATA_SHIFT_WIDTH-1:0]   shift_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_a[g]  = req_data[g*IDATA_WIDTH +: IDATA_WIDTH];
    assign scale_a[g] = req_cfg_scale[g*CDATA_SCALE_WIDTH +: CDATA_SCALE_WIDTH];
    assign bias_a[g]  = req_cfg_bias[g*CDATA_BIAS_WIDTH +: CDATA_BIAS_WIDTH];
    assign shift_a[g] = req_cfg_shift[g*CDATA_SHIFT_WIDTH +: CDATA_SHIFT_WIDTH];
  end

  function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return OW'(s);
  endfunction

  // Descending scan so the requester closest to the rr pointer wins.
  logic          pick_vld;
  logic [OW-1:0] pick_idx;
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(rr_q, k)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_add(rr_q, k);
      end
    end
  end

  logic xfer;
  logic burst_end;
  logic underflow;

  assign xfer      = (state_q == S_STREAM) && req_valid[owner_q];
  assign burst_end = req_last[owner_q] || (beats_q == BCW'(MAX_BURST - 1));

  always_comb begin
    req_ready = '0;
    if (state_q == S_STREAM) req_ready[owner_q] = 1'b1;
  end

  // A result with nothing outstanding is flagged and never decrements.
  always_comb begin
    inflight_d = inflight_q;
    underflow  = q_odata_valid && (inflight_q == '0);
    if (xfer && !(q_odata_valid && !underflow)) begin
      inflight_d = inflight_q + FW'(1);
    end else if (!xfer && q_odata_valid && !underflow) begin
      inflight_d = inflight_q - FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= S_IDLE;
      owner_q         <= '0;
      rr_q            <= '0;
      inflight_q      <= '0;
      beats_q         <= '0;
      cfg_scale_q     <= '0;
      cfg_bias_q      <= '0;
      cfg_shift_q     <= '0;
      q_idata_q       <= '0;
      q_idata_valid_q <= 1'b0;
      rsp_data_q      <= '0;
      rsp_valid_q     <= '0;
      err_q           <= 1'b0;
    end else begin
      q_idata_valid_q <= 1'b0;
      rsp_data_q      <= q_odata;
      rsp_valid_q     <= q_odata_valid ? (NUM_REQ'(1) << owner_q) : '0;
      inflight_q      <= inflight_d;
      if (underflow) err_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            owner_q <= pick_idx;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          cfg_scale_q <= scale_a[owner_q];
          cfg_bias_q  <= bias_a[owner_q];
          cfg_shift_q <= shift_a[owner_q];
          beats_q     <= '0;
          state_q     <= S_STREAM;
        end
        S_STREAM: begin
          if (xfer) begin
            q_idata_q       <= data_a[owner_q];
            q_idata_valid_q <= 1'b1;
            beats_q         <= beats_q + BCW'(1);
            if (burst_end) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Config may only change once every in-flight result is back.
          if (inflight_q == '0) begin
            rr_q    <= wrap_add(owner_q, 1);
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign q_cfg_scale   = cfg_scale_q;
  assign q_cfg_bias    = cfg_bias_q;
  assign q_cfg_shift   = cfg_shift_q;
  assign q_idata       = q_idata_q;
  assign q_idata_valid = q_idata_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_valid     = rsp_valid_q;
  assign busy          = (state_q != S_IDLE);
  assign err_underflow = err_q;

endmodule

// File: tb/tb_core_quant_arbiter.sv
// Randomized bench for core_quant_arbiter with a behavioural quant pipeline stub,
// per-requester expected-result queues and an arbitration order model.
module tb_core_quant_arbiter;
  localparam int NUM_REQ = 2;
  localparam int IW = 24, OB = 8, SW = 16, BW = 16, SHW = 5;
  localparam int MAXB = 4, INFL = 8;
  localparam int LAT = 5;

  typedef struct {
    int len; logic [15:0] sc; logic [15:0] bi; logic [4:0] sh;
    int data0; int expv; bit mid; logic [15:0] mid_sc; bit keep;
    int gap_after; int maxgap;
  } burst_t;
  typedef struct { logic [23:0] d; logic [15:0] sc; logic [15:0] bi; logic [4:0] sh; } qcfg_t;

  logic clk = 1'b0;
  logic rstn;
  logic [NUM_REQ-1:0] req_valid, req_last, req_ready, rsp_valid;
  logic [NUM_REQ*IW-1:0] req_data;
  logic [NUM_REQ*SW-1:0] req_cfg_scale;
  logic [NUM_REQ*BW-1:0] req_cfg_bias;
  logic [NUM_REQ*SHW-1:0] req_cfg_shift;
  logic [SW-1:0] q_cfg_scale;
  logic [BW-1:0] q_cfg_bias;
  logic [SHW-1:0] q_cfg_shift;
  logic [IW-1:0] q_idata;
  logic q_idata_valid, q_odata_valid, busy, err_underflow;
  logic [OB-1:0] q_odata, rsp_data;

  int checks = 0;
  int errors = 0;
  int inject_cnt = 0;
  int spur_exp = 0;
  burst_t bq [NUM_REQ][$];
  int expq [NUM_REQ][$];
  qcfg_t cfgq [$];
  logic stub_pv [LAT+1];
  int rem [NUM_REQ];

  core_quant_arbiter #(
    .NUM_REQ(NUM_REQ), .IDATA_WIDTH(IW), .ODATA_BIT(OB), .CDATA_SCALE_WIDTH(SW),
    .CDATA_BIAS_WIDTH(BW), .CDATA_SHIFT_WIDTH(SHW), .MAX_BURST(MAXB), .INFLIGHT_MAX(INFL)
  ) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .req_cfg_scale(req_cfg_scale), .req_cfg_bias(req_cfg_bias),
    .req_cfg_shift(req_cfg_shift), .q_cfg_scale(q_cfg_scale), .q_cfg_bias(q_cfg_bias),
    .q_cfg_shift(q_cfg_shift), .q_idata(q_idata), .q_idata_valid(q_idata_valid),
    .q_odata(q_odata), .q_odata_valid(q_odata_valid), .rsp_data(rsp_data),
    .rsp_valid(rsp_valid), .busy(busy), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // Quantisation: (d*scale + bias) >> shift, rounded half-up, saturated to 8 bits.
  function automatic int quant(input int d, input int s, input int b, input int sh);
    longint v;
    v = longint'(d) * longint'(s) + longint'(b);
    if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
    if (v > 255) v = 255;
    return int'(v);
  endfunction

  function automatic burst_t mk(input int len, input int sc, input int bi, input int sh,
                                input int d0, input int ev);
    burst_t b;
    b.len = len; b.sc = 16'(sc); b.bi = 16'(bi); b.sh = 5'(sh);
    b.data0 = d0; b.expv = ev; b.mid = 1'b0; b.mid_sc = '0; b.keep = 1'b0;
    b.gap_after = 0; b.maxgap = 0;
    return b;
  endfunction

  function automatic burst_t rnd(input int len);
    return mk(len, $urandom_range(1, 8), $urandom_range(0, 15), $urandom_range(0, 6), -1, -1);
  endfunction

  function automatic burst_t rnd_burst();
    burst_t b;
    b = rnd($urandom_range(1, 7));
    b.gap_after = $urandom_range(0, 3);
    b.maxgap = ($urandom_range(0, 2) == 0) ? 2 : 0;
    b.mid = (b.len >= 2 && b.len <= MAXB && $urandom_range(0, 1) == 1);
    b.mid_sc = 16'($urandom_range(1, 8));
    b.keep = ($urandom_range(0, 3) == 0);
    return b;
  endfunction

  function automatic bit drv_idle();
    for (int r = 0; r < NUM_REQ; r++)
      if (bq[r].size() != 0 || rem[r] != 0 || req_valid[r] || expq[r].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int stub_count();
    int n = 0;
    for (int i = 0; i <= LAT; i++) if (stub_pv[i]) n++;
    return n;
  endfunction

  // Requester drivers: one burst descriptor at a time per requester.
  initial begin : driver
    logic [NUM_REQ-1:0] rdy;
    burst_t cur [NUM_REQ];
    int gapc [NUM_REQ], beatn [NUM_REQ], curd [NUM_REQ];
    logic [15:0] lsc [NUM_REQ], lbi [NUM_REQ];
    logic [4:0] lsh [NUM_REQ];
    qcfg_t qc;
    req_valid = '0; req_last = '0; req_data = '0;
    req_cfg_scale = '0; req_cfg_bias = '0; req_cfg_shift = '0;
    for (int r = 0; r < NUM_REQ; r++) begin rem[r] = 0; gapc[r] = 0; beatn[r] = 0; end
    forever begin
      @(negedge clk) rdy = req_ready;
      @(posedge clk); #1;
      if (!rstn) begin
        req_valid = '0; req_last = '0;
        for (int r = 0; r < NUM_REQ; r++) begin rem[r] = 0; gapc[r] = 0; bq[r].delete(); end
      end else begin
        for (int r = 0; r < NUM_REQ; r++) begin
          if (req_valid[r] && rdy[r]) begin
            expq[r].push_back((cur[r].expv >= 0) ? cur[r].expv :
                              quant(curd[r], int'(lsc[r]), int'(lbi[r]), int'(lsh[r])));
            qc.d = 24'(curd[r]); qc.sc = lsc[r]; qc.bi = lbi[r]; qc.sh = lsh[r];
            cfgq.push_back(qc);
            beatn[r]++; rem[r]--;
            if (cur[r].mid && beatn[r] == 1) req_cfg_scale[r*SW +: SW] = cur[r].mid_sc;
            req_valid[r] = 1'b0; req_last[r] = 1'b0;
            gapc[r] = (rem[r] == 0) ? cur[r].gap_after : $urandom_range(0, cur[r].maxgap);
          end
          if (!req_valid[r]) begin
            if (gapc[r] > 0) begin
              gapc[r]--;
            end else begin
              if (rem[r] == 0 && bq[r].size() != 0) begin
                cur[r] = bq[r].pop_front();
                if (!cur[r].keep) begin
                  req_cfg_scale[r*SW +: SW] = cur[r].sc;
                  req_cfg_bias[r*BW +: BW] = cur[r].bi;
                  req_cfg_shift[r*SHW +: SHW] = cur[r].sh;
                end
                lsc[r] = req_cfg_scale[r*SW +: SW];
                lbi[r] = req_cfg_bias[r*BW +: BW];
                lsh[r] = req_cfg_shift[r*SHW +: SHW];
                rem[r] = cur[r].len; beatn[r] = 0;
              end
              if (rem[r] > 0) begin
                curd[r] = (cur[r].data0 >= 0) ? cur[r].data0 : int'($urandom_range(0, 1000));
                req_data[r*IW +: IW] = IW'(curd[r]);
                req_last[r] = (rem[r] == 1);
                req_valid[r] = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // Quant pipeline stub: fixed latency, uses whatever config the arbiter presents.
  initial begin : quant_stub
    int pd [LAT+1];
    int inj_seen;
    qcfg_t e;
    inj_seen = 0;
    q_odata = '0; q_odata_valid = 1'b0;
    for (int i = 0; i <= LAT; i++) begin stub_pv[i] = 1'b0; pd[i] = 0; end
    forever begin
      @(posedge clk); #2;
      if (!rstn) begin
        for (int i = 0; i <= LAT; i++) stub_pv[i] = 1'b0;
        cfgq.delete();
        q_odata_valid = 1'b0; q_odata = '0;
      end else begin
        for (int i = LAT; i > 0; i--) begin stub_pv[i] = stub_pv[i-1]; pd[i] = pd[i-1]; end
        stub_pv[0] = q_idata_valid;
        pd[0] = quant(int'(q_idata), int'(q_cfg_scale), int'(q_cfg_bias), int'(q_cfg_shift));
        if (q_idata_valid) begin
          if (cfgq.size() == 0) begin
            checks++; errors++;
            $display("FAIL q_idata_unexpected: got data %0d, required no transfer", q_idata);
          end else begin
            e = cfgq.pop_front();
            chk("q_idata", q_idata, e.d);
            chk("q_cfg_scale", q_cfg_scale, e.sc);
            chk("q_cfg_bias", q_cfg_bias, e.bi);
            chk("q_cfg_shift", q_cfg_shift, e.sh);
          end
        end
        q_odata_valid = stub_pv[LAT];
        q_odata = OB'(pd[LAT]);
        if (inject_cnt != inj_seen) begin
          inj_seen++;
          q_odata_valid = 1'b1; q_odata = 8'h5a;
        end
      end
    end
  end

  // Monitor: response routing/data and round-robin grant order.
  initial begin : monitor
    logic [NUM_REQ-1:0] vh1, vh2, prv;
    int model_rr, spur_seen, r, eo;
    spur_seen = 0; model_rr = 0; vh1 = '0; vh2 = '0; prv = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        for (int k = 0; k < NUM_REQ; k++) expq[k].delete();
        model_rr = 0; vh1 = '0; vh2 = '0; prv = '0;
      end else begin
        if (rsp_valid != '0) begin
          if ($countones(rsp_valid) != 1) begin
            chk("rsp_onehot", $countones(rsp_valid), 1);
          end else begin
            r = $clog2(int'(rsp_valid));
            if (expq[r].size() != 0) chk($sformatf("rsp_data_req%0d", r), rsp_data, expq[r].pop_front());
            else if (spur_seen < spur_exp) spur_seen++;
            else begin
              checks++; errors++;
              $display("FAIL rsp_unexpected: rsp_valid=%b data=%0d, required none", rsp_valid, rsp_data);
            end
          end
        end
        if (req_ready != '0) chk("ready_onehot", $countones(req_ready), 1);
        if (req_ready != '0 && prv == '0) begin
          eo = -1;
          for (int k = NUM_REQ - 1; k >= 0; k--)
            if (vh2[(model_rr + k) % NUM_REQ]) eo = (model_rr + k) % NUM_REQ;
          if (eo < 0) begin
            checks++; errors++;
            $display("FAIL grant_owner: ready=%b with no request pending two cycles earlier", req_ready);
          end else begin
            chk("grant_owner", req_ready, longint'(1) << eo);
            model_rr = (eo + 1) % NUM_REQ;
          end
          chk("drain_before_grant", stub_count(), 0);
        end
        vh2 = vh1; vh1 = req_valid; prv = req_ready;
      end
    end
  end

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!(drv_idle() && busy == 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(drv_idle() && busy == 1'b0)) begin
      errors++;
      $display("FAIL %s_idle: busy=%0d after %0d cycles, required idle", tag, busy, n);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_q_cfg_scale"}, q_cfg_scale, 0);
    chk({tag, "_q_cfg_bias"}, q_cfg_bias, 0);
    chk({tag, "_q_cfg_shift"}, q_cfg_shift, 0);
    chk({tag, "_q_idata"}, q_idata, 0);
    chk({tag, "_q_idata_valid"}, q_idata_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err_underflow"}, err_underflow, 0);
  endtask

  initial begin : main
    burst_t b;
    int n;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk_all_zero("reset");
    @(negedge clk) rstn = 1'b1;

    bq[0].push_back(mk(1, 2, 0, 1, 100, 100));
    wait_idle(200, "single_req0");
    bq[1].push_back(mk(1, 3, 1, 2, 10, 8));
    wait_idle(200, "single_req1");

    bq[0].push_back(rnd(3)); bq[1].push_back(rnd(3)); bq[0].push_back(rnd(3));
    wait_idle(500, "alternate");

    bq[0].push_back(rnd(10)); bq[1].push_back(rnd(3));
    wait_idle(800, "max_burst");

    b = mk(3, 2, 0, 4, -1, -1); b.mid = 1'b1; b.mid_sc = 16'd5;
    bq[0].push_back(b);
    b = mk(3, 0, 0, 0, -1, -1); b.keep = 1'b1;
    bq[0].push_back(b);
    wait_idle(500, "cfg_change");

    for (int i = 0; i < 25; i++)
      for (int r = 0; r < NUM_REQ; r++) bq[r].push_back(rnd_burst());
    wait_idle(20000, "random");

    chk("err_before_inject", err_underflow, 0);
    spur_exp++;
    inject_cnt++;
    repeat (4) @(negedge clk);
    chk("err_underflow_set", err_underflow, 1);
    chk("busy_after_inject", busy, 0);
    bq[1].push_back(rnd(4)); bq[0].push_back(rnd(2));
    wait_idle(800, "after_inject");
    chk("err_underflow_sticky", err_underflow, 1);

    bq[0].push_back(rnd(4));
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("stream_reached", req_ready[0], 1);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1 chk_all_zero("midstream_reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    chk("busy_after_reset", busy, 0);

    bq[0].push_back(rnd(3)); bq[1].push_back(rnd(2));
    wait_idle(800, "recovery");
    chk("err_after_recovery", err_underflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded 50000 cycles");
    $fatal(1);
  end
endmodule
